// File: rtl/ram_pkg.sv
// Shared types and byte helpers for the simple-dual-port byte-enable RAM.
package ram_pkg;

  typedef enum logic [0:0] {
    RAM_INIT = 1'b0,
    RAM_RUN  = 1'b1
  } ram_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
    logic [7:0] res;
    if (be) res = new_byte;
    else    res = old_byte;
    return res;
  endfunction

  // Even parity: the stored bit makes the 9-bit group carry an even count of ones.
  function automatic logic byte_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// INIT/RUN sequencer: after reset it walks every address once so the array
// holds a defined value, then hands the write port over to the user.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int AWIDTH = 9
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  output logic [AWIDTH-1:0] sweep_addr,
  output logic              sweep_we
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = '1;

  ram_state_e        state_r;
  ram_state_e        state_nxt_s;
  logic [AWIDTH-1:0] cnt_r;
  logic              busy_r;
  logic              sweep_we_s;

  // state register; busy follows the next state so it drops on the final sweep edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RAM_INIT;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RAM_INIT);
    end
  end

  // sweep address counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (state_r == RAM_INIT) begin
      cnt_r <= cnt_r + AWIDTH'(1'b1);
    end else begin
      cnt_r <= '0;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RAM_INIT: begin
        if (cnt_r == LAST_ADDR) state_nxt_s = RAM_RUN;
        else                    state_nxt_s = RAM_INIT;
      end
      RAM_RUN: state_nxt_s = RAM_RUN;
      default: state_nxt_s = RAM_INIT;
    endcase
  end

  // output decode
  always_comb begin
    sweep_we_s = 1'b0;
    case (state_r)
      RAM_INIT: sweep_we_s = 1'b1;
      RAM_RUN:  sweep_we_s = 1'b0;
      default:  sweep_we_s = 1'b0;
    endcase
  end

  assign init_busy  = busy_r;
  assign sweep_addr = cnt_r;
  assign sweep_we   = sweep_we_s;

endmodule

// File: rtl/ram_sdp_be.sv
// Single-clock simple-dual-port RAM with byte enables, selectable read-during-write,
// optional output stage and post-reset clear sweep. RAM_SDP_BE_PARITY_EN adds per-byte parity.
module ram_sdp_be
  import ram_pkg::*;
#(
  parameter int                AWIDTH     = 9,
  parameter int                DWIDTH     = 32,
  parameter int                OUT_REG    = 0,
  parameter int                RDW_MODE   = 0,
  parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AWIDTH-1:0]    waddr,
  input  logic [DWIDTH/8-1:0]  wbe,
  input  logic [DWIDTH-1:0]    wdata,
  input  logic                 re,
  input  logic [AWIDTH-1:0]    raddr,
  output logic [DWIDTH-1:0]    rdata,
  output logic                 rvalid,
  output logic                 init_busy,
  output logic                 rd_parity_err
);

  localparam int DEPTH  = 2 ** AWIDTH;
  localparam int NBYTES = DWIDTH / 8;

  logic              init_busy_s;
  logic [AWIDTH-1:0] sweep_addr_s;
  logic              sweep_we_s;

  ram_init_seq #(.AWIDTH(AWIDTH)) u_seq (
    .clk        (clk),
    .rst        (rst),
    .init_busy  (init_busy_s),
    .sweep_addr (sweep_addr_s),
    .sweep_we   (sweep_we_s)
  );

  logic [DWIDTH-1:0] mem_r [DEPTH];

  logic              run_we_s, run_re_s, bypass_s, perr_s;
  logic              wr_en_s;
  logic [AWIDTH-1:0] wr_addr_s;
  logic [NBYTES-1:0] wr_be_s;
  logic [DWIDTH-1:0] wr_data_s, wr_old_s, wr_word_s;
  logic [DWIDTH-1:0] rd_old_s, byp_word_s, rd_word_s;

  assign run_we_s = we & ~init_busy_s;
  assign run_re_s = re & ~init_busy_s;
  assign bypass_s = (RDW_MODE == RDW_NEW) && run_we_s && (waddr == raddr);
  assign wr_old_s = mem_r[wr_addr_s];
  assign rd_old_s = mem_r[raddr];

  // write-port mux: the sweep owns the port while busy
  always_comb begin
    if (init_busy_s) begin
      wr_en_s   = sweep_we_s;
      wr_addr_s = sweep_addr_s;
      wr_be_s   = '1;
      wr_data_s = INIT_VALUE;
    end else begin
      wr_en_s   = we;
      wr_addr_s = waddr;
      wr_be_s   = wbe;
      wr_data_s = wdata;
    end
  end

  // byte merges for the stored word and for the same-address read bypass
  always_comb begin
    wr_word_s  = wr_old_s;
    byp_word_s = rd_old_s;
    for (int i = 0; i < NBYTES; i++) begin
      wr_word_s[8*i +: 8]  = byte_merge(wr_old_s[8*i +: 8], wr_data_s[8*i +: 8], wr_be_s[i]);
      byp_word_s[8*i +: 8] = byte_merge(rd_old_s[8*i +: 8], wdata[8*i +: 8], wbe[i]);
    end
    if (bypass_s) rd_word_s = byp_word_s;
    else          rd_word_s = rd_old_s;
  end

  // data array write
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_addr_s] <= wr_word_s;
  end

`ifdef RAM_SDP_BE_PARITY_EN
  logic [NBYTES-1:0] par_r [DEPTH];
  logic [NBYTES-1:0] wr_par_old_s, rd_par_old_s, wr_par_s, rd_par_s;

  assign wr_par_old_s = par_r[wr_addr_s];
  assign rd_par_old_s = par_r[raddr];

  // parity merge, bypass and check mirror the data path byte for byte
  always_comb begin
    wr_par_s = wr_par_old_s;
    rd_par_s = rd_par_old_s;
    perr_s   = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      if (wr_be_s[i]) wr_par_s[i] = byte_parity(wr_data_s[8*i +: 8]);
      else            wr_par_s[i] = wr_par_old_s[i];
      if (bypass_s && wbe[i]) rd_par_s[i] = byte_parity(wdata[8*i +: 8]);
      else                    rd_par_s[i] = rd_par_old_s[i];
    end
    for (int i = 0; i < NBYTES; i++) begin
      perr_s = perr_s | (byte_parity(rd_word_s[8*i +: 8]) ^ rd_par_s[i]);
    end
  end

  // parity array write
  always_ff @(posedge clk) begin
    if (wr_en_s) par_r[wr_addr_s] <= wr_par_s;
  end
`else
  assign perr_s = 1'b0;
`endif

  logic              st_v_s, st_perr_s;
  logic [DWIDTH-1:0] st_d_s;

  if (OUT_REG != 0) begin : g_oreg
    logic              s1_v_r, s1_perr_r;
    logic [DWIDTH-1:0] s1_d_r;

    // extra read stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_v_r    <= 1'b0;
        s1_perr_r <= 1'b0;
        s1_d_r    <= '0;
      end else begin
        s1_v_r <= run_re_s;
        if (run_re_s) begin
          s1_d_r    <= rd_word_s;
          s1_perr_r <= perr_s;
        end
      end
    end

    assign st_v_s    = s1_v_r;
    assign st_d_s    = s1_d_r;
    assign st_perr_s = s1_perr_r;
  end else begin : g_noreg
    assign st_v_s    = run_re_s;
    assign st_d_s    = rd_word_s;
    assign st_perr_s = perr_s;
  end

  logic [DWIDTH-1:0] rdata_r;
  logic              rvalid_r, perr_r;

  // final read register; rdata holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
      perr_r   <= 1'b0;
    end else begin
      rvalid_r <= st_v_s;
      perr_r   <= st_v_s & st_perr_s;
      if (st_v_s) rdata_r <= st_d_s;
    end
  end

  assign rdata         = rdata_r;
  assign rvalid        = rvalid_r;
  assign rd_parity_err = perr_r;
  assign init_busy     = init_busy_s;

endmodule
